// File: rtl/elastic_read_ctrl.sv
// Read-side controller for the RX elastic buffer. Runs in read_clk only.
// Drives the memory read address and enable, tracks fill level against the
// synchronized write pointer, and performs SKP-based clock compensation by
// re-reading or skipping one SKP symbol after a COM.
module elastic_read_ctrl #(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned BUFFER_DEPTH = 16,
    parameter int unsigned ADDR         = $clog2(BUFFER_DEPTH),
    parameter int unsigned START_LEVEL  = BUFFER_DEPTH / 2,
    parameter int unsigned LOW_WM       = BUFFER_DEPTH / 2 - 2,
    parameter int unsigned HIGH_WM      = BUFFER_DEPTH / 2 + 2,
    parameter logic [DATA_WIDTH-1:0] COM_RDN = 10'b0011111010,
    parameter logic [DATA_WIDTH-1:0] COM_RDP = 10'b1100000101
) (
    input  logic                  read_clk,
    input  logic                  rst,
    input  logic [ADDR:0]         write_pointer_gray,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR-1:0]       read_pointer,
    output logic                  rd_en,
    output logic                  empty,
    output logic [ADDR:0]         read_pointer_gray,
    output logic                  data_valid,
    output logic [ADDR:0]         fill_level,
    output logic                  skp_added,
    output logic                  skp_removed,
    output logic                  underflow
);

    localparam logic [ADDR:0] StartLvl = (ADDR + 1)'(START_LEVEL);
    localparam logic [ADDR:0] LowWm    = (ADDR + 1)'(LOW_WM);
    localparam logic [ADDR:0] HighWm   = (ADDR + 1)'(HIGH_WM);

    typedef enum logic {StFill, StRun} state_e;

    state_e        state_q, state_d;
    logic [ADDR:0] rd_bin_q, rd_bin_d;
    logic [ADDR:0] rd_gray_q;
    logic          data_valid_q, data_valid_d;
    logic          skp_added_q, skp_added_d;
    logic          skp_removed_q, skp_removed_d;
    logic          underflow_q, underflow_d;
    logic [ADDR:0] write_bin;
    logic          com_seen;

    function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b = g;
        for (int i = int'(ADDR) - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pointer conversion, occupancy and COM detection at the memory output.
    always_comb begin
        write_bin  = gray2bin(write_pointer_gray);
        fill_level = write_bin - rd_bin_q;
        empty      = (fill_level == '0);
        com_seen   = data_valid_q && ((mem_data == COM_RDN) || (mem_data == COM_RDP));
    end

    // Next-state: fill gating, read enable and SKP add/remove pointer step.
    always_comb begin
        state_d       = state_q;
        rd_bin_d      = rd_bin_q;
        rd_en         = 1'b0;
        skp_added_d   = 1'b0;
        skp_removed_d = 1'b0;
        underflow_d   = 1'b0;
        unique case (state_q)
            StFill: begin
                if (fill_level >= StartLvl) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (fill_level == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    rd_en = 1'b1;
                    if (com_seen && (fill_level < LowWm)) begin
                        // Hold so the SKP now being read is emitted twice.
                        skp_added_d = 1'b1;
                    end else if (com_seen && (fill_level > HighWm)) begin
                        // Skip the second SKP of the ordered set.
                        rd_bin_d      = rd_bin_q + (ADDR + 1)'(2);
                        skp_removed_d = 1'b1;
                    end else begin
                        rd_bin_d = rd_bin_q + (ADDR + 1)'(1);
                    end
                end
            end
            default: state_d = StFill;
        endcase
        data_valid_d = rd_en;
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            state_q       <= StFill;
            rd_bin_q      <= '0;
            rd_gray_q     <= '0;
            data_valid_q  <= 1'b0;
            skp_added_q   <= 1'b0;
            skp_removed_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_bin_q      <= rd_bin_d;
            rd_gray_q     <= rd_bin_d ^ (rd_bin_d >> 1);
            data_valid_q  <= data_valid_d;
            skp_added_q   <= skp_added_d;
            skp_removed_q <= skp_removed_d;
            underflow_q   <= underflow_d;
        end
    end

    assign read_pointer      = rd_bin_q[ADDR-1:0];
    assign read_pointer_gray = rd_gray_q;
    assign data_valid        = data_valid_q;
    assign skp_added         = skp_added_q;
    assign skp_removed       = skp_removed_q;
    assign underflow         = underflow_q;

endmodule

// File: tb/tb_elastic_read_ctrl.sv
// Bench for elastic_read_ctrl: emulates the buffer memory and a writer with
// variable rate, and checks every output each cycle against a pointer model
// kept as plain unbounded integers.
module tb_elastic_read_ctrl;

    localparam logic [9:0] COM_N = 10'b0011111010;
    localparam logic [9:0] COM_P = 10'b1100000101;
    localparam logic [9:0] SKP   = 10'b0011110100;
    localparam int NCYC = 2400;
    localparam int RST_CYC = 1500;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] wpg;
    logic [9:0] mem_data;
    logic [3:0] read_pointer;
    logic       rd_en, empty, data_valid, skp_added, skp_removed, underflow;
    logic [4:0] read_pointer_gray, fill_level;

    always #5 clk = ~clk;

    elastic_read_ctrl dut (
        .read_clk           (clk),
        .rst                (rst),
        .write_pointer_gray (wpg),
        .mem_data           (mem_data),
        .read_pointer       (read_pointer),
        .rd_en              (rd_en),
        .empty              (empty),
        .read_pointer_gray  (read_pointer_gray),
        .data_valid         (data_valid),
        .fill_level         (fill_level),
        .skp_added          (skp_added),
        .skp_removed        (skp_removed),
        .underflow          (underflow)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_add = 0, n_rem = 0, n_uf = 0;

    // Model: pointers as ever-growing integers, buffer contents as an array.
    int         m_rd, m_wr;
    bit         m_run, m_valid, m_add, m_rem, m_uf;
    logic [9:0] m_data;
    logic [9:0] buf_mem [16];
    logic [9:0] wq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int gray5(input int v);
        int b;
        b = v % 32;
        return b ^ (b >> 1);
    endfunction

    task automatic refill();
        if ($urandom_range(0, 4) == 0) begin
            wq.push_back($urandom_range(0, 1) ? COM_P : COM_N);
            repeat (3) wq.push_back(SKP);
        end else begin
            repeat (4) begin
                logic [9:0] d;
                d = 10'($urandom);
                if (d == COM_N || d == COM_P) d = 10'h000;
                wq.push_back(d);
            end
        end
    endtask

    initial begin
        int         fill, nw, r, phase;
        bit         exp_rden, n_run, n_valid, n_add_b, n_rem_b, n_uf_b, do_rst, re;
        int         n_rd;
        logic [9:0] n_data;
        logic [3:0] ra;

        rst = 1'b1;
        wpg = '0;
        mem_data = '0;
        for (int i = 0; i < 16; i++) buf_mem[i] = '0;
        m_rd = 0; m_wr = 0; m_run = 0; m_valid = 0; m_add = 0; m_rem = 0; m_uf = 0;
        m_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            fill = m_wr - m_rd;
            exp_rden = m_run && (fill != 0);

            chk("read_pointer", int'(read_pointer), m_rd % 16);
            chk("read_pointer_gray", int'(read_pointer_gray), gray5(m_rd));
            chk("fill_level", int'(fill_level), fill % 32);
            chk("empty", int'(empty), int'(fill == 0));
            chk("rd_en", int'(rd_en), int'(exp_rden));
            chk("data_valid", int'(data_valid), int'(m_valid));
            chk("skp_added", int'(skp_added), int'(m_add));
            chk("skp_removed", int'(skp_removed), int'(m_rem));
            chk("underflow", int'(underflow), int'(m_uf));

            // Literal anchors for the start-up and mid-stream reset sequences.
            if (cyc == 0) begin
                chk("lit_reset_rp", int'(read_pointer), 0);
                chk("lit_reset_empty", int'(empty), 1);
            end
            if (cyc == 8) begin
                chk("lit_fill8_rden", int'(rd_en), 0);
                chk("lit_fill8_level", int'(fill_level), 8);
            end
            if (cyc == 9) begin
                chk("lit_start_rden", int'(rd_en), 1);
                chk("lit_start_rp", int'(read_pointer), 0);
                chk("lit_start_dv", int'(data_valid), 0);
            end
            if (cyc == 10) begin
                chk("lit_dv1", int'(data_valid), 1);
                chk("lit_rp1", int'(read_pointer), 1);
                chk("lit_fill7", int'(fill_level), 7);
            end
            if (cyc == 11) chk("lit_rp2", int'(read_pointer), 2);
            if (cyc == RST_CYC + 1) begin
                chk("lit_rst_gray", int'(read_pointer_gray), 0);
                chk("lit_rst_rp", int'(read_pointer), 0);
                chk("lit_rst_rden", int'(rd_en), 0);
            end

            // Model step for the coming edge.
            n_run = m_run; n_rd = m_rd; n_valid = 0; n_data = m_data;
            n_add_b = 0; n_rem_b = 0; n_uf_b = 0;
            if (!m_run) begin
                n_run = (fill >= 8);
            end else if (fill == 0) begin
                n_uf_b = 1;
            end else begin
                n_valid = 1;
                n_data  = buf_mem[m_rd % 16];
                if (m_valid && (m_data == COM_N || m_data == COM_P) && fill < 6) begin
                    n_add_b = 1;
                end else if (m_valid && (m_data == COM_N || m_data == COM_P) && fill > 10) begin
                    n_rem_b = 1;
                    n_rd = m_rd + 2;
                end else begin
                    n_rd = m_rd + 1;
                end
            end

            // Writer rate for this edge.
            r = $urandom_range(0, 9);
            phase = (cyc / 150) % 4;
            if (cyc < 8) nw = 1;
            else if (cyc < 16) nw = 0;
            else if (phase == 0) nw = (r < 2) ? 0 : (r < 6) ? 1 : 2;
            else if (phase == 1) nw = (r < 1) ? 0 : (r < 9) ? 1 : 2;
            else if (phase == 2) nw = (r < 4) ? 0 : (r < 9) ? 1 : 2;
            else nw = (cyc % 150 < 40) ? 0 : (r < 2) ? 0 : (r < 6) ? 1 : 2;
            while (m_wr + nw - m_rd > 15) nw--;

            do_rst = (cyc == RST_CYC) || (cyc == RST_CYC + 1);
            rst = do_rst;
            ra = read_pointer;
            re = rd_en;

            @(posedge clk);
            #1;
            if (re) mem_data = buf_mem[ra];
            if (do_rst) begin
                m_rd = 0; m_wr = 0; m_run = 0; m_valid = 0;
                m_add = 0; m_rem = 0; m_uf = 0;
            end else begin
                for (int k = 0; k < nw; k++) begin
                    if (wq.size() == 0) refill();
                    buf_mem[m_wr % 16] = wq.pop_front();
                    m_wr++;
                end
                m_rd = n_rd; m_run = n_run; m_valid = n_valid; m_data = n_data;
                m_add = n_add_b; m_rem = n_rem_b; m_uf = n_uf_b;
                n_add += int'(n_add_b); n_rem += int'(n_rem_b); n_uf += int'(n_uf_b);
            end
            wpg = 5'(gray5(m_wr));
            @(negedge clk);
        end

        $display("coverage: adds=%0d removes=%0d underflow_cycles=%0d", n_add, n_rem, n_uf);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
